prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Input-side counterpart to the board display path: lets the operator write a program into instruction memory from the board, instead of only reading processor state out.
- Debounces two pushbuttons and accumulates eight 4-bit switch nibbles into a 32-bit word.
- Issues one handshaked write per committed word to the instruction-memory write port, auto-incrementing the word address.
- Exposes the word being typed and the current address so the top level can route them to the 7-segment displays.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a key change is accepted (10 ms at 50 MHz); benches use 4.
- ADDR_W, 8: word-address width of the instruction memory.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- reset  input  1  synchronous, active-low reset.
- load_en  input  1  1 = loader owns the memory write port; 0 = loader idle.
- key_digit  input  1  raw pushbutton, active-low (pressed = 0); asynchronous to clk.
- key_write  input  1  raw pushbutton, active-low; asynchronous to clk.
- sw_nibble  input  4  hex digit to append on a digit press.
- wr_ack  input  1  memory accepted the current write (sampled while wr_en=1).
- wr_en  output  1  write request.
- wr_addr  output  ADDR_W  word address of the write.
- wr_data  output  32  word to write.
- shadow_word  output  32  word under construction (display).
- digit_count  output  4  nibbles entered, 0..8.
- err  output  1  sticky: write pressed with an incomplete word.
- busy  output  1  high in WRITE_REQ.

Behaviour:
- Reset (reset=0 at a clk edge): the following outputs are 0:
  - wr_en, wr_addr, wr_data, shadow_word, digit_count, err, busy.
  - Synchronizers are 1 (released), debounce counters 0, stable key state is released, state is ENTRY.
- Key conditioning, per key, identical:
  - Two-flop synchronizer.
  - Counter increments while the synchronized value differs from the stable value and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable value takes the synchronized value and the counter clears.
  - The press pulse is one clk cycle on a stable 1->0 transition; release generates no pulse.
  - Press latency from the raw edge to the pulse is 2 + DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- State ENTRY:
  - A digit pulse with load_en=1 and digit_count<8 sets shadow_word <= {shadow_word[27:0], sw_nibble}, increments digit_count, and clears err.
  - A digit pulse with digit_count=8 is ignored; the word is frozen.
  - A write pulse with load_en=1 and digit_count=8 latches wr_data <= shadow_word, sets wr_en=1 and busy=1, and moves to WRITE_REQ on the next cycle.
  - A write pulse with digit_count<8 sets err=1 and performs no write.
  - Pulses with load_en=0 are discarded.
  - If both pulses arrive in the same cycle, write is processed and digit is discarded.
- State WRITE_REQ:
  - wr_en, wr_addr and wr_data are held stable until wr_ack=1 is sampled.
  - On the ack cycle edge:
    - wr_en=0 and busy=0.
    - wr_addr increments, wrapping (2^ADDR_W)-1 -> 0.
    - shadow_word=0 and digit_count=0.
    - Return to ENTRY.
  - Minimum request width is 1 cycle (ack in the first cycle is legal).
  - All key pulses in WRITE_REQ are discarded, not queued.
  - load_en falling in WRITE_REQ does not abort; the write completes on ack.
  - wr_ack outside WRITE_REQ is ignored.
- Address:
  - wr_addr changes only on ack or reset.
  - load_en 0->1 does not reset it.
- Reset asserted mid-handshake: wr_en drops at that edge, the address returns to 0 and the partial word is lost.

Test Plan:
1. DEBOUNCE_CYCLES=4, key_digit low for 3 cycles then high -> no pulse; shadow_word and digit_count unchanged (0).
2. load_en=1, enter nibbles 1,2,3,4,5,6,7,8 (key held low >=8 cycles each) -> shadow_word=0x12345678, digit_count=8; a ninth press with sw_nibble=F leaves shadow_word unchanged.
3. After scenario 2, press write with wr_ack held 0 for 5 cycles then 1 for 1 cycle:
   - wr_en=1 for exactly 6 cycles with wr_addr=0x00 and wr_data=0x12345678.
   - Next cycle: wr_en=0, wr_addr=0x01, digit_count=0.
4. With 3 nibbles entered, press write -> err=1, wr_en stays 0; the next digit press clears err and digit_count becomes 4.
5. Preload 255 writes so wr_addr=0xFF, then commit word 0xDEADBEEF and ack -> write at 0xFF, then wr_addr=0x00.
6. During WRITE_REQ:
   - Drop load_en and press digit -> write still completes on ack; digit discarded (digit_count=0).
   - Separately, pull reset=0 mid-request -> wr_en=0 and wr_addr=0 at that edge.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: debounced keypad loader that writes 32-bit words into instruction memory
module prog_loader #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic              key_digit,
  input  logic              key_write,
  input  logic [3:0]        sw_nibble,
  input  logic              wr_ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [31:0]       shadow_word,
  output logic [3:0]        digit_count,
  output logic              err,
  output logic              busy
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic {ENTRY, WRITE_REQ} state_t;
  state_t state, state_n;
  logic [1:0] raw, s1, s2, stable, press;
  logic [CW-1:0] cnt [2];
  logic do_write, do_err, do_digit, done;
  assign raw = {key_write, key_digit};
  assign busy = state == WRITE_REQ;
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 2'b11;
      s2 <= 2'b11;
      stable <= 2'b11;
      press <= 2'b00;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      press <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == stable[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= s2[i];
          press[i] <= !s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) state <= ENTRY;
    else state <= state_n;
  end
  always_comb begin
    do_write = state == ENTRY && load_en && press[1] && digit_count == 4'd8;
    do_err = state == ENTRY && load_en && press[1] && digit_count != 4'd8;
    do_digit = state == ENTRY && load_en && press[0] && !press[1] && digit_count < 4'd8;
    done = state == WRITE_REQ && wr_ack;
    state_n = do_write ? WRITE_REQ : done ? ENTRY : state;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      shadow_word <= '0;
      digit_count <= '0;
      err <= 1'b0;
    end else begin
      if (do_digit) begin
        shadow_word <= {shadow_word[27:0], sw_nibble};
        digit_count <= digit_count + 4'd1;
        err <= 1'b0;
      end
      if (do_err) err <= 1'b1;
      if (do_write) begin
        wr_data <= shadow_word;
        wr_en <= 1'b1;
      end
      if (done) begin
        wr_en <= 1'b0;
        wr_addr <= wr_addr + 1'b1;
        shadow_word <= '0;
        digit_count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench with a window-based debounce model and per-cycle compare
module tb_prog_loader;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset, load_en, key_digit, key_write, wr_ack;
  logic [3:0] sw_nibble;
  logic wr_en, err, busy;
  logic [7:0] wr_addr;
  logic [31:0] wr_data, shadow_word;
  logic [3:0] digit_count;
  int passed = 0, total = 0, wen_cycles = 0, w0;
  logic [1:0] h [0:D+1];
  logic [1:0] mst, mp;
  logic all_diff;
  logic m_ok = 1'b0, m_wen, m_err;
  logic [31:0] m_sh, m_data;
  logic [3:0] m_cnt;
  logic [7:0] m_addr;
  logic [7:0] cap_addr, post_addr;
  logic [31:0] cap_data;
  logic post_en;
  logic [3:0] post_cnt;
  prog_loader #(.DEBOUNCE_CYCLES(D), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .key_digit(key_digit),
    .key_write(key_write), .sw_nibble(sw_nibble), .wr_ack(wr_ack), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .shadow_word(shadow_word),
    .digit_count(digit_count), .err(err), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
  endtask
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i <= D + 1; i++) h[i] = 2'b11;
      mst = 2'b11; mp = 2'b00; m_sh = 0; m_cnt = 0; m_err = 0; m_wen = 0; m_addr = 0; m_data = 0;
      m_ok = 1'b1;
    end else begin
      if (m_wen) begin
        if (wr_ack) begin m_wen = 0; m_addr = m_addr + 8'd1; m_sh = 0; m_cnt = 0; end
      end else if (load_en && mp[1]) begin
        if (m_cnt == 4'd8) begin m_data = m_sh; m_wen = 1; end
        else m_err = 1;
      end else if (load_en && mp[0] && m_cnt < 4'd8) begin
        m_sh = (m_sh << 4) | {28'd0, sw_nibble}; m_cnt = m_cnt + 4'd1; m_err = 0;
      end
      for (int i = D + 1; i > 0; i--) h[i] = h[i-1];
      h[0] = {key_write, key_digit};
      for (int k = 0; k < 2; k++) begin
        all_diff = 1'b1;
        for (int i = 2; i <= D + 1; i++) if (h[i][k] == mst[k]) all_diff = 1'b0;
        mp[k] = all_diff && mst[k];
        if (all_diff) mst[k] = ~mst[k];
      end
    end
  end
  always @(negedge clk) begin
    if (m_ok) begin
      chk("wr_en", {31'd0, wr_en}, {31'd0, m_wen});
      chk("busy", {31'd0, busy}, {31'd0, m_wen});
      chk("wr_addr", {24'd0, wr_addr}, {24'd0, m_addr});
      chk("wr_data", wr_data, m_data);
      chk("shadow_word", shadow_word, m_sh);
      chk("digit_count", {28'd0, digit_count}, {28'd0, m_cnt});
      chk("err", {31'd0, err}, {31'd0, m_err});
      if (wr_en === 1'b1) wen_cycles++;
    end
  end
  task automatic digit(input logic [3:0] n);
    sw_nibble = n;
    key_digit = 1'b0;
    repeat (D + 3) @(negedge clk);
    key_digit = 1'b1;
    repeat (D + 3) @(negedge clk);
  endtask
  task automatic enter_word(input logic [31:0] v);
    for (int i = 7; i >= 0; i--) digit(v[4*i +: 4]);
  endtask
  task automatic wait_wen();
    int t = 0;
    while (wr_en !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("wr_en_rise", {31'd0, wr_en}, 32'd1);
  endtask
  task automatic commit(input int dly);
    key_write = 1'b0;
    wait_wen();
    cap_addr = wr_addr;
    cap_data = wr_data;
    repeat (dly) @(negedge clk);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    post_en = wr_en;
    post_addr = wr_addr;
    post_cnt = digit_count;
    key_write = 1'b1;
    repeat (D + 3) @(negedge clk);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b0; load_en = 1'b0; key_digit = 1'b1; key_write = 1'b1; wr_ack = 1'b0; sw_nibble = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_addr", {24'd0, wr_addr}, 32'd0);
    chk("rst_shadow", shadow_word, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    load_en = 1'b1;
    sw_nibble = 4'hA;
    key_digit = 1'b0;
    repeat (3) @(negedge clk);
    key_digit = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_count", {28'd0, digit_count}, 32'd0);
    chk("glitch_shadow", shadow_word, 32'd0);
    enter_word(32'h12345678);
    chk("word_shadow", shadow_word, 32'h12345678);
    chk("word_count", {28'd0, digit_count}, 32'd8);
    digit(4'hF);
    chk("frozen_shadow", shadow_word, 32'h12345678);
    w0 = wen_cycles;
    commit(5);
    chk("req_width", wen_cycles - w0, 32'd6);
    chk("req_addr", {24'd0, cap_addr}, 32'h00);
    chk("req_data", cap_data, 32'h12345678);
    chk("post_en", {31'd0, post_en}, 32'd0);
    chk("post_addr", {24'd0, post_addr}, 32'h01);
    chk("post_cnt", {28'd0, post_cnt}, 32'd0);
    digit(4'h1); digit(4'h2); digit(4'h3);
    w0 = wen_cycles;
    key_write = 1'b0;
    repeat (D + 3) @(negedge clk);
    key_write = 1'b1;
    repeat (D + 3) @(negedge clk);
    chk("err_set", {31'd0, err}, 32'd1);
    chk("err_no_write", wen_cycles - w0, 32'd0);
    digit(4'h4);
    chk("err_clear", {31'd0, err}, 32'd0);
    chk("err_count", {28'd0, digit_count}, 32'd4);
    digit(4'h5); digit(4'h6); digit(4'h7); digit(4'h8);
    w0 = wen_cycles;
    commit(0);
    chk("min_width", wen_cycles - w0, 32'd1);
    chk("min_data", cap_data, 32'h12345678);
    chk("min_post_addr", {24'd0, post_addr}, 32'h02);
    enter_word(32'hCAFEF00D);
    key_write = 1'b0;
    wait_wen();
    load_en = 1'b0;
    sw_nibble = 4'h9;
    key_digit = 1'b0;
    repeat (D + 4) @(negedge clk);
    chk("noabort_busy", {31'd0, busy}, 32'd1);
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    chk("noabort_en", {31'd0, wr_en}, 32'd0);
    chk("noabort_addr", {24'd0, wr_addr}, 32'h03);
    key_digit = 1'b1;
    key_write = 1'b1;
    repeat (D + 3) @(negedge clk);
    load_en = 1'b1;
    chk("noabort_count", {28'd0, digit_count}, 32'd0);
    for (int n = 0; n < 300 && wr_addr !== 8'hFF; n++) begin
      enter_word(32'h0);
      commit(0);
    end
    chk("preload_addr", {24'd0, wr_addr}, 32'hFF);
    enter_word(32'hDEADBEEF);
    commit(2);
    chk("wrap_req_addr", {24'd0, cap_addr}, 32'hFF);
    chk("wrap_data", cap_data, 32'hDEADBEEF);
    chk("wrap_post_addr", {24'd0, post_addr}, 32'h00);
    enter_word(32'h0BADC0DE);
    key_write = 1'b0;
    wait_wen();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_en", {31'd0, wr_en}, 32'd0);
    chk("midrst_addr", {24'd0, wr_addr}, 32'h00);
    chk("midrst_shadow", shadow_word, 32'd0);
    reset = 1'b1;
    key_write = 1'b1;
    repeat (2 * D + 6) @(negedge clk);
    chk("midrst_err", {31'd0, err}, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
